// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and data-length decode for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Code 00..11 selects 5..8 data bits.
  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled start/data/parity/stop detection feeding a flagged FIFO.
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_enable,
  input  logic [1:0] cfg_data_bits,
  input  logic [1:0] cfg_parity,
  input  logic       cfg_stop2,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  rx_state_e        state, nxt;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             tick, half_done, bit_done;
  logic [2:0]       bit_cnt;
  logic [7:0]       data_q;
  logic [3:0]       len_q;
  logic [1:0]       par_q;
  logic             stop2_q, pe_q, fe_q, pbit_q;
  logic             start_det, last_data_bit, stop_fe, is_break;
  logic             push, pop;
  logic [9:0]       push_word, fifo_head;
  logic             fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick          = (div_cnt == DIV_LAST);
  assign half_done     = tick && (os_cnt == OS_HALF);
  assign bit_done      = tick && (os_cnt == OS_LAST);
  assign start_det     = rx_enable && !rx_s;
  assign last_data_bit = ({1'b0, bit_cnt} == (len_q - 4'd1));
  assign stop_fe       = fe_q || !rx_s;
  assign is_break      = (data_q == 8'h00) && !pbit_q && stop_fe;
  assign push_word     = {stop_fe, pe_q, data_q};

  // Both counters sit at zero in IDLE so a new frame starts from a fresh tick phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      if (state == ST_IDLE || tick) div_cnt <= '0;
      else                          div_cnt <= div_cnt + DIV_W'(1);
      if (state == ST_IDLE || (state == ST_START && half_done) || bit_done) os_cnt <= '0;
      else if (tick)                                                       os_cnt <= os_cnt + OS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state != ST_IDLE && !rx_enable) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (start_det) nxt = ST_START;
        ST_START:     if (half_done) nxt = rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:      if (bit_done && last_data_bit) nxt = parity_enabled(par_q) ? ST_PARITY : ST_STOP1;
        ST_PARITY:    if (bit_done) nxt = ST_STOP1;
        ST_STOP1: begin
          if (bit_done) begin
            if (stop2_q) nxt = ST_STOP2;
            else         nxt = is_break ? ST_WAIT_IDLE : ST_IDLE;
          end
        end
        ST_STOP2:     if (bit_done) nxt = is_break ? ST_WAIT_IDLE : ST_IDLE;
        ST_WAIT_IDLE: if (rx_s) nxt = ST_IDLE;
        default:      nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_busy = (state != ST_IDLE);
    push    = 1'b0;
    if (rx_enable && bit_done && (state == ST_STOP2 || (state == ST_STOP1 && !stop2_q)))
      push = 1'b1;
  end

  // Frame configuration is captured at the start edge so later cfg changes cannot corrupt a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      data_q  <= '0;
      len_q   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            len_q   <= data_len(cfg_data_bits);
            par_q   <= cfg_parity;
            stop2_q <= cfg_stop2;
            bit_cnt <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            pbit_q  <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            data_q[bit_cnt] <= rx_s;
            bit_cnt         <= bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            pbit_q <= rx_s;
            pe_q   <= (^data_q) ^ rx_s ^ (par_q == PAR_ODD);
          end
        end
        ST_STOP1: begin
          if (bit_done) fe_q <= !rx_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign pop = !fifo_empty && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= push && fifo_full && !pop;
  end

  uart_rx_fifo #(
    .WIDTH(10),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign parity_error  = !fifo_empty && fifo_head[8];
  assign framing_error = !fifo_empty && fifo_head[9];

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg at 16 clocks per bit: vector table, directed corner cases and a random scoreboard run.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ   = 16000000;
  localparam int BAUD_RATE  = 1000000;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_EVEN = 2'b01;
  localparam logic [1:0] P_ODD  = 2'b10;

  logic       clk = 1'b0;
  logic       reset, rx, rx_enable, rx_ready, cfg_stop2;
  logic [1:0] cfg_data_bits, cfg_parity;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, framing_error, overrun, rx_busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int start_cycle = 0;
  int rise_cycle = -1;
  int overrun_cycles = 0;
  int sb_popped = 0;
  logic sb_enable = 1'b0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] len_code;
    logic [1:0] par;
    logic       stop2;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_rx_cfg #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_enable    (rx_enable),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic popOne();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Sends one frame; cfg inputs are scrambled after the start bit since the receiver must ignore them mid-frame.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] len_code, input logic [1:0] par,
                               input logic stop2, input logic pbit, input logic s1, input logic s2);
    int n;
    n = 5 + int'(len_code);
    @(negedge clk);
    cfg_data_bits = len_code;
    cfg_parity    = par;
    cfg_stop2     = stop2;
    start_cycle   = cycle;
    rise_cycle    = -1;
    driveBit(1'b0);
    cfg_data_bits = 2'($urandom_range(0, 3));
    cfg_parity    = 2'($urandom_range(0, 3));
    cfg_stop2     = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) driveBit(data[i]);
    if (par == P_EVEN || par == P_ODD) driveBit(pbit);
    driveBit(s1);
    if (stop2) driveBit(s2);
    rx = 1'b1;
  endtask

  function automatic logic [9:0] modelFrame(input logic [7:0] data, input logic [1:0] len_code, input logic [1:0] par,
                                            input logic stop2, input logic pbit, input logic s1, input logic s2);
    int n;
    int ones;
    logic [7:0] d;
    logic pe, fe;
    n = 5 + int'(len_code);
    ones = 0;
    d = 8'h00;
    for (int i = 0; i < n; i++) begin
      d[i] = data[i];
      ones += int'(data[i]);
    end
    pe = 1'b0;
    if (par == P_EVEN)     pe = ((ones + int'(pbit)) % 2) != 0;
    else if (par == P_ODD) pe = ((ones + int'(pbit)) % 2) != 1;
    fe = !s1 || (stop2 && !s2);
    return {fe, pe, d};
  endfunction

  function automatic int lastStopMid(input logic [1:0] len_code, input logic [1:0] par, input logic stop2);
    int total;
    total = 1 + 5 + int'(len_code) + ((par == P_EVEN || par == P_ODD) ? 1 : 0) + 1 + int'(stop2);
    return (total - 1) * BIT_CLKS + BIT_CLKS / 2;
  endfunction

  always @(negedge clk) begin
    if (overrun) overrun_cycles++;
    if (rx_valid && !prev_valid) rise_cycle = cycle;
    prev_valid = rx_valid;
    if (sb_enable && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got entry 0x%0h, expected none", {framing_error, parity_error, rx_data});
      end else begin
        checkOutput("sb_entry", {22'd0, framing_error, parity_error, rx_data}, {22'd0, exp_q.pop_front()});
        sb_popped++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{8'hA5, 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h35, 2'd2, P_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, 8'h35, 1'b1, 1'b0};
    vecs[2] = '{8'h35, 2'd2, P_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
    vecs[3] = '{8'h1F, 2'd0, P_ODD,  1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1};
    vecs[4] = '{8'h2A, 2'd1, P_ODD,  1'b0, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 2'd3, 2'b11,  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h3C, 2'd3, P_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[7] = '{8'hF3, 2'd0, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
    vecs[8] = '{8'hC4, 2'd3, P_ODD,  1'b1, 1'b0, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b0};
    vecs[9] = '{8'h40, 2'd2, P_EVEN, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b1};

    reset = 1'b1;
    rx = 1'b1;
    rx_enable = 1'b0;
    rx_ready = 1'b0;
    cfg_data_bits = 2'd3;
    cfg_parity = P_NONE;
    cfg_stop2 = 1'b0;
    idle(5);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_parity_error", parity_error, 1'b0);
    checkOutput("reset_framing_error", framing_error, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_rx_busy", rx_busy, 1'b0);
    reset = 1'b0;
    rx_enable = 1'b1;
    idle(5);

    $display("[TB] vector table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].data, vecs[v].len_code, vecs[v].par, vecs[v].stop2, vecs[v].pbit, vecs[v].s1, vecs[v].s2);
      idle(20);
      checkOutput($sformatf("vec%0d_valid", v), rx_valid, 1'b1);
      checkOutput($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_pe", v), parity_error, vecs[v].exp_pe);
      checkOutput($sformatf("vec%0d_fe", v), framing_error, vecs[v].exp_fe);
      checkRange($sformatf("vec%0d_valid_latency", v), rise_cycle - start_cycle,
                 lastStopMid(vecs[v].len_code, vecs[v].par, vecs[v].stop2),
                 lastStopMid(vecs[v].len_code, vecs[v].par, vecs[v].stop2) + 6);
      popOne();
      checkOutput($sformatf("vec%0d_empty_after_pop", v), rx_valid, 1'b0);
      checkOutput($sformatf("vec%0d_data_zero_when_empty", v), rx_data, 8'h00);
      checkOutput($sformatf("vec%0d_idle", v), rx_busy, 1'b0);
    end

    $display("[TB] false start");
    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2);
    checkOutput("false_start_busy", rx_busy, 1'b1);
    idle(40);
    checkOutput("false_start_idle", rx_busy, 1'b0);
    checkOutput("false_start_no_push", rx_valid, 1'b0);
    popOne();
    checkOutput("pop_while_empty", rx_valid, 1'b0);

    $display("[TB] break");
    cfg_data_bits = 2'd3;
    cfg_parity = P_NONE;
    cfg_stop2 = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    idle(40 * BIT_CLKS);
    checkOutput("break_busy", rx_busy, 1'b1);
    checkOutput("break_valid", rx_valid, 1'b1);
    checkOutput("break_data", rx_data, 8'h00);
    checkOutput("break_fe", framing_error, 1'b1);
    checkOutput("break_pe", parity_error, 1'b0);
    rx = 1'b1;
    idle(40);
    checkOutput("break_idle", rx_busy, 1'b0);
    popOne();
    checkOutput("break_single_entry", rx_valid, 1'b0);

    $display("[TB] overrun");
    overrun_cycles = 0;
    for (int f = 0; f < 9; f++) begin
      applyStimulus(8'(f), 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(20);
    end
    checkOutput("overrun_pulses", overrun_cycles, 1);
    for (int f = 0; f < 8; f++) begin
      checkOutput($sformatf("overrun_pop%0d", f), {rx_valid, rx_data}, {1'b1, 8'(f)});
      popOne();
    end
    checkOutput("overrun_drained", rx_valid, 1'b0);

    $display("[TB] enable abort");
    applyStimulus(8'h5A, 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(20);
    fork
      applyStimulus(8'hC3, 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        idle(60);
        checkOutput("abort_busy_before", rx_busy, 1'b1);
        rx_enable = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle_next_cycle", rx_busy, 1'b0);
      end
    join
    idle(20);
    rx_enable = 1'b1;
    idle(20);
    checkOutput("abort_fifo_kept", {rx_valid, rx_data}, {1'b1, 8'h5A});
    popOne();
    checkOutput("abort_no_push", rx_valid, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h11, 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(20);
    fork
      applyStimulus(8'h33, 2'd3, P_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        idle(50);
        reset = 1'b1;
        idle(2);
        checkOutput("midreset_valid", rx_valid, 1'b0);
        checkOutput("midreset_busy", rx_busy, 1'b0);
        checkOutput("midreset_data", rx_data, 8'h00);
      end
    join
    idle(5);
    reset = 1'b0;
    idle(40);
    checkOutput("midreset_no_frame", {rx_valid, rx_busy}, 2'b00);

    $display("[TB] random frames");
    rx_ready = 1'b1;
    sb_enable = 1'b1;
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic [1:0] lc, pm;
      logic st2, pb, s1, s2;
      d   = 8'($urandom);
      lc  = 2'($urandom_range(0, 3));
      pm  = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ($urandom_range(0, 5) != 0);
      exp_q.push_back(modelFrame(d, lc, pm, st2, pb, s1, s2));
      applyStimulus(d, lc, pm, st2, pb, s1, s2);
      idle(24);
    end
    idle(20);
    sb_enable = 1'b0;
    checkOutput("sb_drained", exp_q.size(), 0);
    checkOutput("sb_count", sb_popped, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
